// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-requester arbiter sharing one AXI read AR/R channel pair
//
// Purpose: arbitrates instruction fetch (requester 0) and data load (requester 1)
// onto a single AXI read port, one fixed-length INCR burst at a time, and steers
// every returned beat to the requester that owns the burst in flight.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   rq_valid[1:0]       request strobes (bit 0 fetch, bit 1 load)
//   rq_addr0, rq_addr1  request addresses
//   rq_ready[1:0]       one-hot accept strobe
//   rsp_valid[1:0]      one-hot beat strobe to the burst owner
//   rsp_data            beat data (shared)
//   rsp_last, rsp_err   final beat of burst, burst error (valid with rsp_last)
//   m_axi_ar*           AXI read address channel (master side)
//   m_axi_r*            AXI read data channel (master side)

module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rq_valid,
  input  logic [ADDR_WIDTH-1:0] rq_addr0,
  input  logic [ADDR_WIDTH-1:0] rq_addr1,
  output logic [1:0]            rq_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t     state, state_next;
  logic       owner;
  logic       prio;
  logic [7:0] beat_cnt;
  logic       err_flag;

  logic       winner;
  logic       accept;
  logic       beat_err;
  logic       burst_end;

  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner};
  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;

  // Protocol check on the beat currently presented; only meaningful in DATA.
  assign beat_err = (m_axi_rresp != 2'b00)
                  | (m_axi_rid != m_axi_arid)
                  | ( m_axi_rlast & (beat_cnt != LAST_BEAT))
                  | (~m_axi_rlast & (beat_cnt == LAST_BEAT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    rq_ready     = 2'b00;
    rsp_valid    = 2'b00;
    rsp_data     = '0;
    rsp_last     = 1'b0;
    rsp_err      = 1'b0;
    m_axi_rready = 1'b0;
    accept       = 1'b0;
    burst_end    = 1'b0;

    // A lone request wins outright; a tie goes to whichever side prio names.
    winner = prio;
    if (rq_valid == 2'b01) begin
      winner = 1'b0;
    end else if (rq_valid == 2'b10) begin
      winner = 1'b1;
    end

    case (state)
      S_IDLE: begin
        // Gated by reset so no accept strobe leaks out while held in reset.
        if (reset && (rq_valid != 2'b00)) begin
          accept           = 1'b1;
          rq_ready[winner] = 1'b1;
          state_next       = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_arvalid && m_axi_arready) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        m_axi_rready     = 1'b1;
        rsp_valid[owner] = m_axi_rvalid;
        rsp_data         = m_axi_rdata;
        rsp_last         = m_axi_rvalid & m_axi_rlast;
        rsp_err          = rsp_last & (err_flag | beat_err);
        if (m_axi_rvalid && m_axi_rlast) begin
          burst_end  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner         <= 1'b0;
      prio          <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      beat_cnt      <= 8'd0;
      err_flag      <= 1'b0;
    end else begin
      if (accept) begin
        owner         <= winner;
        m_axi_arvalid <= 1'b1;
        // Bursts always start on a 64-byte line boundary.
        m_axi_araddr  <= (winner ? rq_addr1 : rq_addr0) & ~ADDR_WIDTH'(6'h3f);
      end else if (m_axi_arvalid && m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
      end

      if (burst_end) begin
        prio     <= ~owner;
        beat_cnt <= 8'd0;
        err_flag <= 1'b0;
      end else if ((state == S_DATA) && m_axi_rvalid) begin
        // Saturate so an over-long burst cannot wrap back onto LAST_BEAT.
        if (beat_cnt != 8'hff) begin
          beat_cnt <= beat_cnt + 8'd1;
        end
        if (beat_err) begin
          err_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized self-checking bench for axi_read_arbiter

module tb_axi_read_arbiter;

  localparam int ID_WIDTH   = 13;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int BURST_LEN  = 8;

  logic                  clk;
  logic                  reset;
  logic [1:0]            rq_valid;
  logic [ADDR_WIDTH-1:0] rq_addr0;
  logic [ADDR_WIDTH-1:0] rq_addr1;
  logic [1:0]            rq_ready;
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  rsp_err;
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int m_prio   = 0;  // reference model: requester that wins a tie

  axi_read_arbiter #(
    .ID_WIDTH  (ID_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rq_valid     (rq_valid),
    .rq_addr0     (rq_addr0),
    .rq_addr1     (rq_addr1),
    .rq_ready     (rq_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .rsp_err      (rsp_err),
    .m_axi_arid   (m_axi_arid),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid    (m_axi_rid),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction; called just after a falling edge, returns just after one.
  // bad_resp / bad_id name a beat carrying an error (-1 for none).
  task automatic run_burst(input logic [1:0] rqv, input logic [63:0] a0, input logic [63:0] a1,
                           input int ar_wait, input int nbeats, input int bad_resp,
                           input int bad_id, input bit hold_rq, input int max_gap);
    int          w;
    logic [63:0] exp_addr;
    logic [1:0]  exp_onehot;
    bit          exp_err;
    bit          is_last;
    logic [63:0] d;
    w          = (rqv == 2'b01) ? 0 : (rqv == 2'b10) ? 1 : m_prio;
    exp_onehot = (w == 0) ? 2'b01 : 2'b10;
    exp_addr   = ((w == 0) ? a0 : a1) / 64 * 64;
    exp_err    = (nbeats != BURST_LEN) || (bad_resp >= 0 && bad_resp < nbeats)
                 || (bad_id >= 0 && bad_id < nbeats);
    rq_valid = rqv; rq_addr0 = a0; rq_addr1 = a1; m_axi_arready = 1'b0;
    #1;
    n_checks++; if (rq_ready !== exp_onehot) begin n_fail++; $display("FAIL accept_rq_ready: got %b expected %b", rq_ready, exp_onehot); end
    n_checks++; if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL arvalid_in_accept_cycle: got %b expected 0", m_axi_arvalid); end
    @(negedge clk);
    if (!hold_rq) rq_valid = 2'b00;
    rq_addr0 = {$urandom, $urandom}; rq_addr1 = {$urandom, $urandom};
    #1;
    n_checks++; if (m_axi_arvalid !== 1'b1) begin n_fail++; $display("FAIL arvalid_first: got %b expected 1", m_axi_arvalid); end
    n_checks++; if (m_axi_araddr !== exp_addr) begin n_fail++; $display("FAIL araddr: got %h expected %h", m_axi_araddr, exp_addr); end
    n_checks++; if (m_axi_arid !== ID_WIDTH'(w)) begin n_fail++; $display("FAIL arid: got %0d expected %0d", m_axi_arid, w); end
    n_checks++; if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {8'(BURST_LEN-1), 3'd3, 2'b01})
      begin n_fail++; $display("FAIL ar_consts: got len %0d size %0d burst %0d expected 7 3 1", m_axi_arlen, m_axi_arsize, m_axi_arburst); end
    for (int i = 0; i < ar_wait; i++) begin
      // Stray beats while the address is pending must be ignored.
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = ID_WIDTH'(w);
      @(negedge clk); #1;
      n_checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_addr)
        begin n_fail++; $display("FAIL ar_hold: got arvalid %b addr %h expected 1 %h", m_axi_arvalid, m_axi_araddr, exp_addr); end
      n_checks++; if (m_axi_rready !== 1'b0 || rsp_valid !== 2'b00 || rsp_last !== 1'b0)
        begin n_fail++; $display("FAIL addr_beat_ignored: got rready %b rsp_valid %b last %b expected 0 00 0", m_axi_rready, rsp_valid, rsp_last); end
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    #1;
    n_checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1)
      begin n_fail++; $display("FAIL enter_data: got arvalid %b rready %b expected 0 1", m_axi_arvalid, m_axi_rready); end
    for (int b = 0; b < nbeats; b++) begin
      int gap;
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        m_axi_rvalid = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL gap_rsp_valid: got %b expected 00", rsp_valid); end
        @(negedge clk);
      end
      d       = {$urandom, $urandom};
      is_last = (b == nbeats - 1);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rresp  = (b == bad_resp) ? 2'b10 : 2'b00;
      m_axi_rid    = (b == bad_id) ? ID_WIDTH'(w ^ 1) : ID_WIDTH'(w);
      m_axi_rlast  = is_last;
      #1;
      n_checks++; if (rsp_valid !== exp_onehot || rsp_data !== d)
        begin n_fail++; $display("FAIL beat%0d_fwd: got valid %b data %h expected %b %h", b, rsp_valid, rsp_data, exp_onehot, d); end
      n_checks++; if (rsp_last !== is_last || rsp_err !== (is_last && exp_err))
        begin n_fail++; $display("FAIL beat%0d_last_err: got last %b err %b expected %b %b", b, rsp_last, rsp_err, is_last, is_last && exp_err); end
      if (hold_rq) begin
        n_checks++; if (rq_ready !== 2'b00) begin n_fail++; $display("FAIL no_accept_in_data: got %b expected 00", rq_ready); end
      end
      @(negedge clk);
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    m_prio = (w == 0) ? 1 : 0;
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    n_checks++;
    if ({rq_ready, rsp_valid, rsp_last, rsp_err, m_axi_arvalid, m_axi_rready} !== 8'd0 || m_axi_araddr !== '0 || rsp_data !== '0)
      begin n_fail++; $display("FAIL %s: got rq_ready %b rsp_valid %b last %b err %b arvalid %b rready %b araddr %h expected all zero",
                               tag, rq_ready, rsp_valid, rsp_last, rsp_err, m_axi_arvalid, m_axi_rready, m_axi_araddr); end
  endtask

  task automatic test_reset();
    rq_valid = 2'b11;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rq_valid = 2'b00; reset = 1'b1;
    #1;
    n_checks++; if (m_axi_rready !== 1'b0 || m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got rready %b arvalid %b expected 0 0", m_axi_rready, m_axi_arvalid); end
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    run_burst(2'b01, 64'h1004, 64'h0, 0, BURST_LEN, -1, -1, 1'b0, 0);
  endtask

  task automatic test_simultaneous();
    run_burst(2'b11, 64'h2000, 64'h3050, 0, BURST_LEN, -1, -1, 1'b1, 1);  // fetch wins
    run_burst(2'b11, 64'h2000, 64'h3050, 0, BURST_LEN, -1, -1, 1'b1, 0);  // load next cycle
    run_burst(2'b11, 64'h4444, 64'h5555, 0, BURST_LEN, -1, -1, 1'b0, 0);  // fetch again
  endtask

  task automatic test_idle_beats();
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 2'b00 || m_axi_rready !== 1'b0 || rsp_last !== 1'b0)
      begin n_fail++; $display("FAIL idle_beat_ignored: got valid %b rready %b last %b expected 00 0 0", rsp_valid, m_axi_rready, rsp_last); end
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  task automatic test_ar_backpressure();
    run_burst(2'b10, 64'h0, 64'hdead_beef, 5, BURST_LEN, -1, -1, 1'b0, 0);
  endtask

  task automatic test_error_resp();
    run_burst(2'b01, 64'h8000, 64'h0, 0, BURST_LEN, 3, -1, 1'b0, 0);
    run_burst(2'b01, 64'h8040, 64'h0, 0, BURST_LEN, -1, -1, 1'b0, 0);
    run_burst(2'b10, 64'h0, 64'h9000, 1, BURST_LEN, -1, 6, 1'b0, 0);
  endtask

  task automatic test_short_burst();
    run_burst(2'b01, 64'ha000, 64'h0, 0, 6, -1, -1, 1'b0, 0);
    #1;
    n_checks++; if (m_axi_rready !== 1'b0) begin n_fail++; $display("FAIL short_back_to_idle: got rready %b expected 0", m_axi_rready); end
    @(negedge clk);
    run_burst(2'b01, 64'ha000, 64'h0, 0, 10, -1, -1, 1'b0, 0);  // rlast missing on beat 7
  endtask

  task automatic test_reset_mid_burst();
    run_burst(2'b01, 64'hb000, 64'h0, 0, BURST_LEN, -1, -1, 1'b0, 0);  // model prio now favours load
    rq_valid = 2'b01; rq_addr0 = 64'hc000;
    @(negedge clk);
    rq_valid = 2'b00; m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_axi_rvalid = 1'b1; m_axi_rid = '0; m_axi_rlast = 1'b0; m_axi_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    m_axi_rvalid = 1'b1;
    #1 reset = 1'b0;
    rq_valid = 2'b11;
    check_all_zero("reset_mid_burst");
    @(negedge clk);
    check_all_zero("held_in_reset");
    m_axi_rvalid = 1'b0; rq_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    m_prio = 0;
    @(negedge clk);
    run_burst(2'b11, 64'hd000, 64'he000, 0, BURST_LEN, -1, -1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [1:0] rqv;
      int         nb;
      rqv = 2'($urandom_range(1, 3));
      nb  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : BURST_LEN;
      run_burst(rqv, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), nb,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1,
                1'b0, 2);
    end
  endtask

  initial begin
    reset = 1'b0; rq_valid = 2'b00; rq_addr0 = '0; rq_addr1 = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_idle_beats();
    test_ar_backpressure();
    test_error_resp();
    test_short_burst();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI read address (AR) and read data (R) channels of the top-level bus port between two requesters: requester 0 is instruction fetch and requester 1 is data load.
- Issues one fixed-length INCR burst at a time, so at most one burst is outstanding.
- Returns each beat only to the requester that owns the current burst.
- Replaces the ad-hoc fetch FSM that currently drives m_axi_ar*/m_axi_r* directly.

Parameters:
- ID_WIDTH, 13, width of the AXI ID fields
- ADDR_WIDTH, 64, width of request and AXI addresses
- DATA_WIDTH, 64, width of the AXI data bus
- BURST_LEN, 8, beats per burst; m_axi_arlen = BURST_LEN-1

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- rq_valid  in  2  per-requester request strobe; bit 0 = fetch, bit 1 = load
- rq_addr0  in  ADDR_WIDTH  fetch request address
- rq_addr1  in  ADDR_WIDTH  load request address
- rq_ready  out  2  one-hot request-accepted strobe
- rsp_valid  out  2  one-hot beat-valid strobe to the burst owner
- rsp_data  out  DATA_WIDTH  beat data, shared by both requesters
- rsp_last  out  1  final beat of the burst
- rsp_err  out  1  burst error, valid with rsp_last
- m_axi_arid  out  ID_WIDTH  owner index zero-extended
- m_axi_araddr  out  ADDR_WIDTH  burst base address
- m_axi_arlen  out  8  constant BURST_LEN-1
- m_axi_arsize  out  3  constant 3'd3 (8 bytes)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address ready
- m_axi_rid  in  ID_WIDTH  read ID
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  beat valid
- m_axi_rready  out  1  beat ready

Behaviour:
- Reset values:
  - State is IDLE; owner=0; prio=0, so fetch is favoured first.
  - m_axi_arvalid=0, m_axi_araddr=0, m_axi_rready=0.
  - rq_ready=0, rsp_valid=0, rsp_last=0, rsp_err=0, beat counter=0, error flag=0.
- States:
  - IDLE: no burst in progress.
  - ADDR: address phase. m_axi_arvalid=1 is registered and held, with araddr and arid stable, until arvalid&arready. At that edge the FSM moves to DATA and arvalid drops the next cycle.
  - DATA: m_axi_rready=1 combinationally.
- Arbitration in IDLE, combinational:
  - If only one rq_valid bit is set, that requester wins.
  - If both are set, the requester selected by prio wins.
  - rq_ready[winner]=1 in that same cycle. This is the accept handshake, and the requester may drop or change rq_valid afterwards.
  - At the clock edge: owner<=winner; araddr<=rq_addrW with bits [5:0] cleared (64-byte line alignment); state<=ADDR.
  - m_axi_arvalid is first high 1 cycle after the accept cycle.
- Data forwarding in DATA, zero latency:
  - rsp_valid[owner] = m_axi_rvalid; rsp_data = m_axi_rdata; rsp_last = m_axi_rvalid & m_axi_rlast.
  - Requesters cannot stall; rready is never deasserted inside a burst.
- Beat counter: counts accepted beats.
- Error flag: set on any accepted beat with rresp!=0, rid!=owner, rlast before beat BURST_LEN-1, or no rlast on beat BURST_LEN-1.
  - rsp_err = error flag OR the current beat's error condition, qualified by rsp_last.
- Burst end: the burst ends only on rvalid&rlast.
  - Next state is IDLE; prio <= ~owner (the requester that was just served loses ties); counter and error flag cleared.
  - A new accept in IDLE is earliest 1 cycle after rlast.
- Beats outside DATA: rvalid seen in IDLE or ADDR is ignored; rready=0 and nothing is forwarded.
- Reset asserted mid-burst: all state is cleared immediately; no rsp_valid after reset; the partially transferred burst is abandoned.

Test Plan:
1. Fetch request only: rq_valid=01, rq_addr0=0x1004, arready=1 at the first arvalid cycle, then 8 beats with rlast on beat 7 -> rq_ready=01 in cycle 0; araddr=0x1000, arlen=7, arsize=3, arburst=1, arid=0; rsp_valid[0] for 8 beats; rsp_last on beat 7; rsp_err=0.
2. Simultaneous requests after reset: rq_valid=11 -> fetch is served first; load is granted 1 cycle after the fetch rlast with arid=1. A second simultaneous request then grants fetch, because prio toggles.
3. AR backpressure: arready held low for 5 cycles -> arvalid stays 1 with araddr constant; DATA is entered only after the handshake.
4. Error response: rresp=2'b10 on beat 3 -> rsp_err=1 with rsp_last on beat 7; the next burst has rsp_err=0.
5. Short burst: rlast on beat 5 -> burst ends, rsp_err=1, and the FSM returns to IDLE.
6. Reset mid-burst: reset=0 during beat 4 -> all outputs are 0 asynchronously; after release, a fetch request is accepted normally with prio=0.
